effect_noise_gate: RTL and testbench

- Sample-rate noise gate that sits directly upstream of the EQ stage and feeds its i_data/i_valid.
- A peak envelope follower drives a 5-state gate FSM. The FSM ramps a Q1.15 gain between 0 and unity, and the gain is applied to each sample.
- Mutes pickup hiss between notes before tone shaping; bypassable with i_enable.

---
 rtl/effect_noise_gate.sv | 170 +++++++++++++++++
 tb/tb_effect_noise_gate.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/effect_noise_gate.sv
// Sample-rate noise gate: peak envelope follower driving a gain-ramping gate FSM.
// Define NOISE_GATE_STATUS_EN to expose o_gate_state and o_gain.
module effect_noise_gate #(
    parameter int HOLD_SAMPLES = 2400,
    parameter int ATTACK_STEP  = 1024,
    parameter int RELEASE_STEP = 32,
    parameter int DECAY_SHIFT  = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic               i_enable,
    input  logic [2:0]         i_level_threshold,
    input  logic signed [15:0] i_data,
    output logic signed [15:0] o_data,
    output logic               o_valid
`ifdef NOISE_GATE_STATUS_EN
    ,
    output logic [2:0]         o_gate_state,
    output logic [16:0]        o_gain
`endif
);

    localparam logic [16:0] UNITY = 17'd32768;
    localparam int HOLD_W = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_SAMPLES - 1);
    localparam logic [16:0] REL_STEP = 17'(RELEASE_STEP);

    typedef enum logic [2:0] {
        CLOSED  = 3'd0,
        ATTACK  = 3'd1,
        OPEN    = 3'd2,
        HOLD    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [16:0]         gain_q, gain_d;
    logic [15:0]         env_q, env_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic signed [15:0]  data_q, data_d;
    logic                valid_q;

    logic [15:0]         mag, decay, env_next, open_thr, close_thr;
    logic [17:0]         gain_up;
    logic [16:0]         gain_up_sat, gain_dn;
    logic signed [32:0]  product;
    logic                unused_product;

    // Product never exceeds 2^30 in magnitude, so bits [30:15] are the exact Q1.15 result
    assign product        = $signed({{17{i_data[15]}}, i_data}) * $signed({16'b0, gain_q});
    assign unused_product = ^{product[32:31], product[14:0]};

    always_comb begin
        if (i_data[15]) begin
            mag = (i_data == 16'sh8000) ? 16'h7FFF : 16'(-i_data);
        end else begin
            mag = i_data;
        end
        decay = env_q >> DECAY_SHIFT;
        if (decay == 16'd0) begin
            decay = 16'd1;
        end
        if (mag >= env_q) begin
            env_next = mag;
        end else if (env_q > decay) begin
            env_next = env_q - decay;
        end else begin
            env_next = 16'd0;
        end
        open_thr  = 16'd64 << i_level_threshold;
        close_thr = open_thr - (open_thr >> 2);
        gain_up     = {1'b0, gain_q} + 18'(ATTACK_STEP);
        gain_up_sat = (gain_up > {1'b0, UNITY}) ? UNITY : gain_up[16:0];
        gain_dn     = (gain_q > REL_STEP) ? (gain_q - REL_STEP) : 17'd0;
    end

    // Gate FSM: bypass overrides every cycle, otherwise decisions happen only on valid samples
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        hold_d  = hold_q;
        env_d   = env_q;
        data_d  = data_q;
        if (i_valid) begin
            env_d  = env_next;
            data_d = i_enable ? product[30:15] : i_data;
        end
        if (!i_enable) begin
            state_d = OPEN;
            gain_d  = UNITY;
            hold_d  = '0;
        end else if (i_valid) begin
            case (state_q)
                CLOSED: begin
                    gain_d = 17'd0;
                    if (env_next >= open_thr) begin
                        gain_d  = gain_up_sat;
                        state_d = (gain_up_sat == UNITY) ? OPEN : ATTACK;
                    end
                end
                ATTACK: begin
                    gain_d = gain_up_sat;
                    if (gain_up_sat == UNITY) begin
                        state_d = OPEN;
                    end
                end
                OPEN: begin
                    gain_d = UNITY;
                    if (env_next < close_thr) begin
                        state_d = HOLD;
                        hold_d  = '0;
                    end
                end
                HOLD: begin
                    gain_d = UNITY;
                    if (env_next >= open_thr) begin
                        state_d = OPEN;
                    end else if (hold_q == HOLD_LAST) begin
                        state_d = RELEASE;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                RELEASE: begin
                    // A re-trigger keeps this sample's gain and resumes the ramp from it
                    if (env_next >= open_thr) begin
                        state_d = ATTACK;
                    end else begin
                        gain_d = gain_dn;
                        if (gain_dn == 17'd0) begin
                            state_d = CLOSED;
                        end
                    end
                end
                default: begin
                    state_d = CLOSED;
                    gain_d  = 17'd0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= CLOSED;
            gain_q  <= 17'd0;
            env_q   <= 16'd0;
            hold_q  <= '0;
            data_q  <= 16'sd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            env_q   <= env_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            valid_q <= i_valid;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;

`ifdef NOISE_GATE_STATUS_EN
    assign o_gate_state = state_q;
    assign o_gain       = gain_q;
`endif

endmodule

// File: tb/tb_effect_noise_gate.sv
// Scoreboard bench for effect_noise_gate: a reference model queues expected samples,
// a monitor compares them as o_valid appears, and scenario tasks check gate state/gain.
module tb_effect_noise_gate;

    localparam int HOLD = 40;
    localparam logic [2:0] S_CLOSED  = 3'd0;
    localparam logic [2:0] S_ATTACK  = 3'd1;
    localparam logic [2:0] S_OPEN    = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    logic               clk;
    logic               i_rst;
    logic               i_valid;
    logic               i_enable;
    logic [2:0]         i_level_threshold;
    logic signed [15:0] i_data;
    logic signed [15:0] o_data;
    logic               o_valid;
`ifdef NOISE_GATE_STATUS_EN
    logic [2:0]         o_gate_state;
    logic [16:0]        o_gain;
`endif

    int vectors;
    int miscompares;
    int expq[$];
    int m_state, m_gain, m_env, m_hold;

    effect_noise_gate #(
        .HOLD_SAMPLES(HOLD),
        .ATTACK_STEP (1024),
        .RELEASE_STEP(32),
        .DECAY_SHIFT (6)
    ) dut (
        .i_clk            (clk),
        .i_rst            (i_rst),
        .i_valid          (i_valid),
        .i_enable         (i_enable),
        .i_level_threshold(i_level_threshold),
        .i_data           (i_data),
        .o_data           (o_data),
        .o_valid          (o_valid)
`ifdef NOISE_GATE_STATUS_EN
        ,
        .o_gate_state     (o_gate_state),
        .o_gain           (o_gain)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of one clock cycle; pushes the expected output of each valid sample
    task automatic model_step(input bit rst, input bit valid, input bit en, input int d, input int thr);
        int a, dec, envn, openv, closev;
        if (rst) begin
            m_state = 0; m_gain = 0; m_env = 0; m_hold = 0;
            return;
        end
        envn = m_env;
        openv = 64 << thr;
        closev = openv - openv / 4;
        if (valid) begin
            a = (d < 0) ? -d : d;
            if (a > 32767) a = 32767;
            dec = m_env / 64;
            if (dec < 1) dec = 1;
            if (a >= m_env) envn = a;
            else envn = (m_env - dec > 0) ? m_env - dec : 0;
            expq.push_back(en ? ((d * m_gain) >>> 15) : d);
            m_env = envn;
        end
        if (!en) begin
            m_state = 2; m_gain = 32768; m_hold = 0;
        end else if (valid) begin
            case (m_state)
                0: begin
                    m_gain = 0;
                    if (envn >= openv) begin m_gain = 1024; m_state = 1; end
                end
                1: begin
                    m_gain = m_gain + 1024;
                    if (m_gain >= 32768) begin m_gain = 32768; m_state = 2; end
                end
                2: begin
                    m_gain = 32768;
                    if (envn < closev) begin m_state = 3; m_hold = 0; end
                end
                3: begin
                    if (envn >= openv) m_state = 2;
                    else if (m_hold == HOLD - 1) m_state = 4;
                    else m_hold = m_hold + 1;
                end
                default: begin
                    if (envn >= openv) m_state = 1;
                    else begin
                        m_gain = (m_gain > 32) ? m_gain - 32 : 0;
                        if (m_gain == 0) m_state = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit valid, input bit en,
                                 input logic signed [15:0] d, input logic [2:0] thr);
        @(negedge clk);
        i_rst = rst; i_valid = valid; i_enable = en; i_data = d; i_level_threshold = thr;
        model_step(rst, valid, en, int'(d), int'(thr));
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every output strobe must match the oldest queued expectation
    always @(negedge clk) begin
        int e;
        if (o_valid === 1'b1) begin
            vectors++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL scoreboard_underflow: o_data=%0d with no expected sample", o_data);
            end else begin
                e = expq.pop_front();
                if (o_data !== 16'(e)) begin
                    miscompares++;
                    $display("[TB] FAIL scoreboard_data: got %0d expected %0d", o_data, 16'(e));
                end
            end
        end
    end

    task automatic test_reset();
        applyStimulus(1, 0, 1, 0, 3);
        applyStimulus(1, 0, 1, 0, 3);
        vectors++;
        if (o_valid !== 1'b0 || o_data !== 16'sd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got valid=%0b data=%0d expected 0/0", o_valid, o_data);
        end
        vectors++;
        if (dut.state_q !== S_CLOSED || dut.gain_q !== 17'd0 || dut.env_q !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got state=%0d gain=%0d env=%0d expected 0/0/0",
                     dut.state_q, dut.gain_q, dut.env_q);
        end
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 1, 1, 0, 3);
            vectors++;
            if (o_valid !== 1'b1 || o_data !== 16'sd0) begin
                miscompares++;
                $display("[TB] FAIL silence_sample%0d: got valid=%0b data=%0d expected 1/0", k, o_valid, o_data);
            end
        end
        applyStimulus(0, 0, 1, 0, 3);
        vectors++;
        if (o_valid !== 1'b0 || dut.state_q !== S_CLOSED) begin
            miscompares++;
            $display("[TB] FAIL silence_end: got valid=%0b state=%0d expected 0/0", o_valid, dut.state_q);
        end
    endtask

    task automatic test_open_ramp();
        for (int k = 1; k <= 33; k++) begin
            applyStimulus(0, 1, 1, 2000, 3);
            vectors++;
            if (o_data !== 16'((2000 * (k - 1) * 1024) >>> 15)) begin
                miscompares++;
                $display("[TB] FAIL ramp_data%0d: got %0d expected %0d", k, o_data, (2000 * (k - 1) * 1024) >>> 15);
            end
            vectors++;
            if (dut.gain_q !== 17'((k >= 32) ? 32768 : k * 1024) ||
                dut.state_q !== ((k >= 32) ? S_OPEN : S_ATTACK)) begin
                miscompares++;
                $display("[TB] FAIL ramp_gain%0d: got gain=%0d state=%0d", k, dut.gain_q, dut.state_q);
            end
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 1, 2000, 3);
            vectors++;
            if (o_data !== 16'sd2000) begin
                miscompares++;
                $display("[TB] FAIL open_data: got %0d expected 2000", o_data);
            end
        end
    endtask

    task automatic test_hold_release();
        int n;
        n = 0;
        while (dut.state_q !== S_HOLD && n < 1000) begin
            applyStimulus(0, 1, 1, 0, 3);
            n++;
        end
        vectors++;
        if (dut.state_q !== S_HOLD || dut.env_q >= 16'd384) begin
            miscompares++;
            $display("[TB] FAIL enter_hold: got state=%0d env=%0d expected HOLD with env<384", dut.state_q, dut.env_q);
        end
        n = 0;
        while (dut.state_q === S_HOLD && n < HOLD + 20) begin
            applyStimulus(0, 1, 1, (n % 2) ? 16'sd100 : -16'sd100, 3);
            n++;
        end
        vectors++;
        if (n != HOLD || dut.state_q !== S_RELEASE || dut.gain_q !== 17'd32768) begin
            miscompares++;
            $display("[TB] FAIL hold_length: got %0d samples state=%0d gain=%0d expected %0d/RELEASE/32768",
                     n, dut.state_q, dut.gain_q, HOLD);
        end
        applyStimulus(0, 1, 1, 16'sd100, 3);
        vectors++;
        if (dut.gain_q !== 17'd32736) begin
            miscompares++;
            $display("[TB] FAIL release_step: got %0d expected 32736", dut.gain_q);
        end
        n = 1;
        while (dut.state_q === S_RELEASE && n < 1100) begin
            applyStimulus(0, 1, 1, (n % 2) ? 16'sd100 : -16'sd100, 3);
            n++;
        end
        vectors++;
        if (n != 1024 || dut.state_q !== S_CLOSED || dut.gain_q !== 17'd0) begin
            miscompares++;
            $display("[TB] FAIL release_length: got %0d samples state=%0d gain=%0d expected 1024/CLOSED/0",
                     n, dut.state_q, dut.gain_q);
        end
    endtask

    task automatic test_retrigger();
        int n;
        for (int k = 0; k < 33; k++) applyStimulus(0, 1, 1, 2000, 3);
        n = 0;
        while (dut.state_q !== S_RELEASE && n < 1000) begin
            applyStimulus(0, 1, 1, 0, 3);
            n++;
        end
        n = 0;
        while (dut.gain_q !== 17'd20000 && n < 1100) begin
            applyStimulus(0, 1, 1, 0, 3);
            n++;
        end
        vectors++;
        if (dut.gain_q !== 17'd20000 || dut.state_q !== S_RELEASE) begin
            miscompares++;
            $display("[TB] FAIL reach_20000: got gain=%0d state=%0d expected 20000/RELEASE", dut.gain_q, dut.state_q);
        end
        applyStimulus(0, 1, 1, 3000, 3);
        vectors++;
        if (dut.state_q !== S_ATTACK || dut.gain_q !== 17'd20000) begin
            miscompares++;
            $display("[TB] FAIL retrigger: got state=%0d gain=%0d expected ATTACK/20000", dut.state_q, dut.gain_q);
        end
        n = 0;
        while (dut.state_q !== S_OPEN && n < 40) begin
            applyStimulus(0, 1, 1, 3000, 3);
            n++;
        end
        vectors++;
        if (n != (32768 - 20000 + 1023) / 1024 || dut.gain_q !== 17'd32768) begin
            miscompares++;
            $display("[TB] FAIL reramp: got %0d samples gain=%0d expected %0d/32768",
                     n, dut.gain_q, (32768 - 20000 + 1023) / 1024);
        end
    endtask

    task automatic test_edge_bypass();
        int n;
        applyStimulus(0, 1, 1, -16'sd32768, 3);
        vectors++;
        if (dut.env_q !== 16'd32767 || o_data !== -16'sd32768) begin
            miscompares++;
            $display("[TB] FAIL edge_mag: got env=%0d data=%0d expected 32767/-32768", dut.env_q, o_data);
        end
        n = 0;
        while (dut.state_q !== S_RELEASE && n < 3000) begin
            applyStimulus(0, 1, 1, 0, 3);
            n++;
        end
        for (int k = 0; k < 5; k++) applyStimulus(0, 1, 1, 0, 3);
        vectors++;
        if (dut.state_q !== S_RELEASE) begin
            miscompares++;
            $display("[TB] FAIL pre_bypass: got state=%0d expected RELEASE", dut.state_q);
        end
        applyStimulus(0, 1, 0, 1234, 3);
        vectors++;
        if (o_data !== 16'sd1234 || dut.state_q !== S_OPEN || dut.gain_q !== 17'd32768 || dut.env_q !== 16'd1234) begin
            miscompares++;
            $display("[TB] FAIL bypass: got data=%0d state=%0d gain=%0d env=%0d expected 1234/OPEN/32768/1234",
                     o_data, dut.state_q, dut.gain_q, dut.env_q);
        end
        applyStimulus(0, 1, 1, 1234, 3);
        vectors++;
        if (o_data !== 16'sd1234 || dut.state_q !== S_OPEN) begin
            miscompares++;
            $display("[TB] FAIL reenable: got data=%0d state=%0d expected 1234/OPEN", o_data, dut.state_q);
        end
    endtask

    task automatic test_threshold();
        applyStimulus(1, 0, 1, 0, 7);
        applyStimulus(0, 1, 1, 5000, 7);
        vectors++;
        if (dut.state_q !== S_CLOSED) begin
            miscompares++;
            $display("[TB] FAIL thr_high_closed: got state=%0d expected CLOSED", dut.state_q);
        end
        applyStimulus(0, 1, 1, 10, 2);
        vectors++;
        if (dut.state_q !== S_ATTACK || dut.gain_q !== 17'd1024) begin
            miscompares++;
            $display("[TB] FAIL thr_low_open: got state=%0d gain=%0d expected ATTACK/1024", dut.state_q, dut.gain_q);
        end
    endtask

    task automatic test_reset_mid_attack();
        applyStimulus(1, 0, 1, 0, 3);
        for (int k = 0; k < 8; k++) applyStimulus(0, 1, 1, 2000, 3);
        vectors++;
        if (dut.gain_q !== 17'd8192 || dut.state_q !== S_ATTACK) begin
            miscompares++;
            $display("[TB] FAIL pre_reset: got gain=%0d state=%0d expected 8192/ATTACK", dut.gain_q, dut.state_q);
        end
        applyStimulus(1, 1, 1, 2000, 3);
        vectors++;
        if (o_data !== 16'sd0 || o_valid !== 1'b0 || dut.gain_q !== 17'd0 || dut.state_q !== S_CLOSED) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_attack: got data=%0d valid=%0b gain=%0d state=%0d expected 0/0/0/CLOSED",
                     o_data, o_valid, dut.gain_q, dut.state_q);
        end
        applyStimulus(0, 0, 1, 0, 3);
    endtask

    task automatic checkOutput();
        applyStimulus(0, 0, 1, 0, 3);
        applyStimulus(0, 0, 1, 0, 3);
        vectors++;
        if (expq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending samples expected 0", expq.size());
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        i_rst = 1'b1; i_valid = 1'b0; i_enable = 1'b1; i_data = 16'sd0; i_level_threshold = 3'd3;
        test_reset();
        test_open_ramp();
        test_hold_release();
        test_retrigger();
        test_edge_bypass();
        test_threshold();
        test_reset_mid_attack();
        checkOutput();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
